// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared opcodes, FSM state encoding and opcode legality helper
//
// Purpose : constants shared by the ALU and the two-requester arbiter.
// Contents: OP_* function codes, state_t (IDLE/EXEC/RESP), op_legal().
package alu_arbiter_pkg;

  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [5:0] sig);
    case (sig)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ALU_32bits.sv
// rtl/ALU_32bits.sv - combinational 32-bit ALU (AND, OR, ADD, SUB, SLT)
//
// Purpose : pure combinational datapath used by alu_arbiter.
// Ports   : dataA, dataB  - 32-bit operands
//           signal        - 6-bit function code
//           dataOut       - 32-bit result (0 for unknown codes)
module ALU_32bits
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  signal,
  output logic [31:0] dataOut
);

  always_comb begin
    dataOut = 32'd0;
    case (signal)
      OP_AND: dataOut = dataA & dataB;
      OP_OR:  dataOut = dataA | dataB;
      OP_ADD: dataOut = dataA + dataB;
      OP_SUB: dataOut = dataA - dataB;
      // Set-less-than compares as two's-complement signed values.
      OP_SLT: dataOut = ($signed(dataA) < $signed(dataB)) ? 32'd1 : 32'd0;
      default: dataOut = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a single shared ALU
//
// Purpose : accepts one operation at a time from requester 0 or 1, runs it
//           through ALU_32bits and returns the result to the granted requester.
// Ports   : clk, rst_n (sync, active-low)
//           reqN_valid/ready/dataA/dataB/signal - request channel, N=0,1
//           rspN_valid/ready/data/err           - response channel, N=0,1
//           busy                                - transaction in flight
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dataA,
  input  logic [WIDTH-1:0] req0_dataB,
  input  logic [SIG_W-1:0] req0_signal,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dataA,
  input  logic [WIDTH-1:0] req1_dataB,
  input  logic [SIG_W-1:0] req1_signal,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             rr_q, rr_d;        // requester preferred on a tie
  logic             grant_q, grant_d;  // requester owning the transaction
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] alu_out;
  logic             any_req;
  logic             pick;
  logic             rsp_hs;

  ALU_32bits u_alu (
    .dataA  (a_q),
    .dataB  (b_q),
    .signal (sig_q),
    .dataOut(alu_out)
  );

  always_comb begin
    any_req = req0_valid | req1_valid;
    // Tie goes to the pointer; otherwise whoever is valid.
    pick    = (req0_valid && req1_valid) ? rr_q : req1_valid;
    rsp_hs  = grant_q ? rsp1_ready : rsp0_ready;

    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    sig_d   = sig_q;
    res_d   = res_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          a_d     = pick ? req1_dataA  : req0_dataA;
          b_d     = pick ? req1_dataB  : req0_dataB;
          sig_d   = pick ? req1_signal : req0_signal;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = op_legal(sig_q) ? alu_out : '0;
        err_d   = ~op_legal(sig_q);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          rr_d    = ~grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      grant_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sig_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sig_q   <= sig_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Outputs are gated by rst_n so they read 0 in the cycle reset is applied,
  // before the state registers have been cleared.
  assign req0_ready = rst_n && (state_q == ST_IDLE) && any_req && !pick;
  assign req1_ready = rst_n && (state_q == ST_IDLE) && any_req &&  pick;
  assign rsp0_valid = rst_n && (state_q == ST_RESP) && !grant_q;
  assign rsp1_valid = rst_n && (state_q == ST_RESP) &&  grant_q;
  assign rsp0_data  = rst_n ? res_q : '0;
  assign rsp1_data  = rst_n ? res_q : '0;
  assign rsp0_err   = rst_n && err_q;
  assign rsp1_err   = rst_n && err_q;
  assign busy       = rst_n && (state_q != ST_IDLE);

endmodule
